// File: rtl/parking_gate_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_arbiter_if
// Brief    : Lane request / gate command / occupancy bundle for the shared
//            barrier-gate arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface parking_gate_arbiter_if #(
  parameter int CNT_W = 5
);
  logic             entry_req;
  logic             exit_req;
  logic             pass_sensor;
  logic             gate_open;
  logic             entry_grant;
  logic             exit_grant;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             timeout_pulse;

  // Lane controllers / sensor side: drives requests, observes the gate.
  modport master (
    output entry_req, exit_req, pass_sensor,
    input  gate_open, entry_grant, exit_grant, occupancy, full, empty,
           timeout_pulse
  );

  // Arbiter side.
  modport slave (
    input  entry_req, exit_req, pass_sensor,
    output gate_open, entry_grant, exit_grant, occupancy, full, empty,
           timeout_pulse
  );
endinterface
`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_arbiter
// Brief    : Grants one barrier gate to the entrance or exit lane (round-robin
//            on contention), times each passage, tracks lot occupancy and
//            refuses entry when full / exit when empty.
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_arbiter #(
  parameter int CAPACITY      = 16,
  parameter int CNT_W         = 5,
  parameter int PASS_TIMEOUT  = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  parking_gate_arbiter_if.slave  bus
);

  localparam int c_WAIT_W = $clog2(PASS_TIMEOUT);
  localparam int c_SET_W  = $clog2(SETTLE_CYCLES + 1);

  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(PASS_TIMEOUT - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
  localparam logic [c_SET_W-1:0]  c_SET_LAST  = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [c_SET_W-1:0]  c_SET_ONE   = c_SET_W'(1);
  localparam logic [CNT_W-1:0]    c_CAP       = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0]    c_OCC_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_ENTRY = 2'd1,
    GRANT_EXIT  = 2'd2,
    SETTLE      = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_next;
  logic [c_SET_W-1:0]  r_settle_cnt;
  logic [c_SET_W-1:0]  w_settle_next;
  logic [CNT_W-1:0]    r_occ;
  logic [CNT_W-1:0]    w_occ_next;
  logic                r_last_was_entry;
  logic                w_last_next;
  logic                w_timeout;

  logic                r_gate_open;
  logic                r_entry_grant;
  logic                r_exit_grant;
  logic                r_timeout_pulse;

  logic                w_full;
  logic                w_empty;
  logic                w_entry_elig;
  logic                w_exit_elig;

  assign w_full       = (r_occ == c_CAP);
  assign w_empty      = (r_occ == '0);
  assign w_entry_elig = bus.entry_req & ~w_full;
  assign w_exit_elig  = bus.exit_req  & ~w_empty;

  // Next-state, counters, occupancy and round-robin update.
  always_comb begin
    w_state_next  = r_state;
    w_wait_next   = r_wait_cnt;
    w_settle_next = r_settle_cnt;
    w_occ_next    = r_occ;
    w_last_next   = r_last_was_entry;
    w_timeout     = 1'b0;

    case (r_state)
      IDLE: begin
        w_wait_next   = '0;
        w_settle_next = '0;
        if (w_entry_elig && w_exit_elig) begin
          // Entry served last -> exit's turn, and vice versa.
          w_state_next = r_last_was_entry ? GRANT_EXIT : GRANT_ENTRY;
        end else if (w_entry_elig) begin
          w_state_next = GRANT_ENTRY;
        end else if (w_exit_elig) begin
          w_state_next = GRANT_EXIT;
        end
      end

      GRANT_ENTRY: begin
        w_wait_next = r_wait_cnt + c_WAIT_ONE;
        if (bus.pass_sensor) begin
          // The full guard is redundant with eligibility but keeps the count
          // from ever wrapping.
          if (!w_full) w_occ_next = r_occ + c_OCC_ONE;
          w_state_next  = SETTLE;
          w_settle_next = '0;
          w_last_next   = 1'b1;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_timeout     = 1'b1;
          w_state_next  = SETTLE;
          w_settle_next = '0;
          w_last_next   = 1'b1;
        end
      end

      GRANT_EXIT: begin
        w_wait_next = r_wait_cnt + c_WAIT_ONE;
        if (bus.pass_sensor) begin
          if (!w_empty) w_occ_next = r_occ - c_OCC_ONE;
          w_state_next  = SETTLE;
          w_settle_next = '0;
          w_last_next   = 1'b0;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_timeout     = 1'b1;
          w_state_next  = SETTLE;
          w_settle_next = '0;
          w_last_next   = 1'b0;
        end
      end

      SETTLE: begin
        w_settle_next = r_settle_cnt + c_SET_ONE;
        if (r_settle_cnt == c_SET_LAST) begin
          w_state_next  = IDLE;
          w_settle_next = '0;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered gate outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_wait_cnt       <= '0;
      r_settle_cnt     <= '0;
      r_occ            <= '0;
      r_last_was_entry <= 1'b1;
      r_gate_open      <= 1'b0;
      r_entry_grant    <= 1'b0;
      r_exit_grant     <= 1'b0;
      r_timeout_pulse  <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_wait_cnt       <= w_wait_next;
      r_settle_cnt     <= w_settle_next;
      r_occ            <= w_occ_next;
      r_last_was_entry <= w_last_next;
      r_gate_open      <= (w_state_next == GRANT_ENTRY) ||
                          (w_state_next == GRANT_EXIT);
      r_entry_grant    <= (w_state_next == GRANT_ENTRY);
      r_exit_grant     <= (w_state_next == GRANT_EXIT);
      r_timeout_pulse  <= w_timeout;
    end
  end

  assign bus.gate_open     = r_gate_open;
  assign bus.entry_grant   = r_entry_grant;
  assign bus.exit_grant    = r_exit_grant;
  assign bus.timeout_pulse = r_timeout_pulse;
  assign bus.occupancy     = r_occ;
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_gate_arbiter
// Brief    : Scoreboard bench for parking_gate_arbiter. Stimulus pushes the
//            expected grant record; a monitor pops it when a grant ends.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_gate_arbiter;

  logic clk;
  logic reset_n;

  parking_gate_arbiter_if #(.CNT_W(5)) bus ();

  parking_gate_arbiter #(
    .CAPACITY      (16),
    .CNT_W         (5),
    .PASS_TIMEOUT  (32),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // lane: 1 = entry, 0 = exit; gap: closed cycles before this grant (0 = any)
  typedef struct {
    bit lane;
    int len;
    int occ;
    bit tmo;
    int gap;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor-private state
  bit   m_prev_open = 0;
  int   m_open_len  = 0;
  bit   m_lane      = 0;
  int   m_closed    = 0;

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(bit lane, int len, int occ, bit tmo, int gap);
    exp_t e;
    e.lane = lane; e.len = len; e.occ = occ; e.tmo = tmo; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic wait_open(string name);
    int k = 0;
    while (!bus.gate_open && k < 200) begin
      cyc(1);
      k++;
    end
    check({name, "_grant_seen"}, int'(bus.gate_open), 1);
  endtask

  task automatic wait_closed(string name);
    int k = 0;
    while (bus.gate_open && k < 200) begin
      cyc(1);
      k++;
    end
    check({name, "_gate_closed"}, int'(bus.gate_open), 0);
  endtask

  // Called right after a grant is seen (grant cycle 1): pass on grant cycle k.
  task automatic do_pass(int k);
    cyc(k - 1);
    bus.pass_sensor = 1'b1;
    cyc(1);
    bus.pass_sensor = 1'b0;
  endtask

  task automatic entry_pass(int k, int occ_after, int gap);
    push(1'b1, k, occ_after, 1'b0, gap);
    bus.entry_req = 1'b1;
    wait_open("entry");
    bus.entry_req = 1'b0;
    do_pass(k);
  endtask

  // Scoreboard monitor: samples on the falling edge, pops on grant end.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_prev_open = 0;
      m_open_len  = 0;
      m_closed    = 0;
    end else begin
      checks++;
      if (bus.entry_grant && bus.exit_grant) begin
        errors++;
        $display("FAIL grant_exclusive: entry_grant=1 exit_grant=1, required at most one");
      end
      if (bus.gate_open && !m_prev_open) begin
        m_open_len = 0;
        m_lane     = bus.entry_grant;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: entry_grant=%0b exit_grant=%0b, required no grant",
                   bus.entry_grant, bus.exit_grant);
        end else if (q[0].gap != 0 && m_closed != q[0].gap) begin
          errors++;
          $display("FAIL grant_gap: closed %0d cycles, required %0d", m_closed, q[0].gap);
        end
      end
      if (bus.gate_open) begin
        m_open_len++;
        if ((bus.entry_grant != m_lane) || (bus.exit_grant == m_lane)) begin
          checks++;
          errors++;
          $display("FAIL grant_stable: entry_grant=%0b exit_grant=%0b, required lane %0b held",
                   bus.entry_grant, bus.exit_grant, m_lane);
        end
      end
      if (!bus.gate_open && m_prev_open) begin
        m_closed = 0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_end: grant ended with nothing expected");
        end else begin
          exp_t e;
          e = q.pop_front();
          checks += 4;
          if (m_lane != e.lane) begin
            errors++;
            $display("FAIL grant_lane: entry=%0b, required entry=%0b", m_lane, e.lane);
          end
          if (m_open_len != e.len) begin
            errors++;
            $display("FAIL open_len: %0d cycles, required %0d", m_open_len, e.len);
          end
          if (int'(bus.occupancy) != e.occ) begin
            errors++;
            $display("FAIL occ_after: %0d, required %0d", bus.occupancy, e.occ);
          end
          if (bus.timeout_pulse != e.tmo) begin
            errors++;
            $display("FAIL timeout_flag: %0b, required %0b", bus.timeout_pulse, e.tmo);
          end
        end
      end else if (bus.timeout_pulse) begin
        checks++;
        errors++;
        $display("FAIL timeout_stray: timeout_pulse=1 outside first settle cycle, required 0");
      end
      if (!bus.gate_open) m_closed++;
      m_prev_open = bus.gate_open;
    end
  end

  // Directed stimulus.
  initial begin
    int opened;
    reset_n         = 1'b0;
    bus.entry_req   = 1'b0;
    bus.exit_req    = 1'b0;
    bus.pass_sensor = 1'b0;
    cyc(3);

    // Reset values
    check("rst_gate_open",   int'(bus.gate_open),     0);
    check("rst_entry_grant", int'(bus.entry_grant),   0);
    check("rst_exit_grant",  int'(bus.exit_grant),    0);
    check("rst_timeout",     int'(bus.timeout_pulse), 0);
    check("rst_occupancy",   int'(bus.occupancy),     0);
    check("rst_full",        int'(bus.full),          0);
    check("rst_empty",       int'(bus.empty),         1);
    reset_n = 1'b1;
    cyc(2);

    // Spurious sensor pulses in IDLE
    repeat (3) begin
      bus.pass_sensor = 1'b1; cyc(1);
      bus.pass_sensor = 1'b0; cyc(1);
    end
    check("spurious_occ", int'(bus.occupancy), 0);

    // Exit request while empty is ignored
    bus.exit_req = 1'b1;
    cyc(10);
    check("empty_exit_gate", int'(bus.gate_open), 0);
    check("empty_exit_occ",  int'(bus.occupancy), 0);
    bus.exit_req = 1'b0;
    cyc(2);

    // Single entry, pass on 3rd grant cycle; request held for a second grant
    check("pre_entry_empty", int'(bus.empty), 1);
    push(1'b1, 3, 1, 1'b0, 0);
    push(1'b1, 1, 2, 1'b0, 5);
    bus.entry_req = 1'b1;
    wait_open("single");
    check("single_entry_grant", int'(bus.entry_grant), 1);
    do_pass(3);
    check("single_occ",      int'(bus.occupancy), 1);
    check("single_empty",    int'(bus.empty),     0);
    check("single_gate_low", int'(bus.gate_open), 0);
    wait_open("second");
    bus.entry_req = 1'b0;
    do_pass(1);
    entry_pass(2, 3, 0);

    // Reset in the middle of an entry grant with occupancy 3
    push(1'b1, 0, 0, 1'b0, 0);
    bus.entry_req = 1'b1;
    wait_open("midgrant");
    check("midgrant_occ", int'(bus.occupancy), 3);
    reset_n = 1'b0;
    bus.entry_req = 1'b0;
    #1;
    check("mid_rst_gate_open",   int'(bus.gate_open),     0);
    check("mid_rst_entry_grant", int'(bus.entry_grant),   0);
    check("mid_rst_exit_grant",  int'(bus.exit_grant),    0);
    check("mid_rst_timeout",     int'(bus.timeout_pulse), 0);
    check("mid_rst_occ",         int'(bus.occupancy),     0);
    check("mid_rst_full",        int'(bus.full),          0);
    check("mid_rst_empty",       int'(bus.empty),         1);
    q.delete();
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    // Fill to 5, then contention: exit, entry, exit, entry
    for (int i = 0; i < 5; i++) entry_pass(1, i + 1, 0);
    push(1'b0, 2, 4, 1'b0, 0);
    push(1'b1, 2, 5, 1'b0, 5);
    push(1'b0, 2, 4, 1'b0, 5);
    push(1'b1, 2, 5, 1'b0, 5);
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_open("contend");
      do_pass(2);
    end
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    check("contend_occ", int'(bus.occupancy), 5);

    // Fill to capacity, then entry is refused
    for (int i = 5; i < 16; i++) entry_pass(1, i + 1, 0);
    cyc(6);
    check("full_occ",   int'(bus.occupancy), 16);
    check("full_flag",  int'(bus.full),      1);
    check("full_empty", int'(bus.empty),     0);
    bus.entry_req = 1'b1;
    opened = 0;
    repeat (20) begin
      cyc(1);
      if (bus.gate_open || bus.entry_grant) opened++;
    end
    check("full_no_grant", opened, 0);

    // Exit frees a space; held entry is granted afterwards
    push(1'b0, 2, 15, 1'b0, 0);
    push(1'b1, 2, 16, 1'b0, 5);
    bus.exit_req = 1'b1;
    wait_open("full_exit");
    check("full_exit_grant", int'(bus.exit_grant), 1);
    bus.exit_req = 1'b0;
    do_pass(2);
    check("after_exit_occ",  int'(bus.occupancy), 15);
    check("after_exit_full", int'(bus.full),      0);
    wait_open("refill");
    check("refill_entry_grant", int'(bus.entry_grant), 1);
    bus.entry_req = 1'b0;
    do_pass(2);

    // One more exit to leave room for the timeout case
    push(1'b0, 1, 15, 1'b0, 0);
    bus.exit_req = 1'b1;
    wait_open("exit2");
    bus.exit_req = 1'b0;
    do_pass(1);

    // Timeout: no passage
    push(1'b1, 32, 15, 1'b1, 0);
    bus.entry_req = 1'b1;
    wait_open("timeout");
    bus.entry_req = 1'b0;
    wait_closed("timeout");
    check("timeout_pulse_hi", int'(bus.timeout_pulse), 1);
    check("timeout_occ",      int'(bus.occupancy),     15);
    cyc(1);
    check("timeout_pulse_lo", int'(bus.timeout_pulse), 0);

    // Pass on the final grant cycle (counter 31): passage wins
    push(1'b1, 32, 16, 1'b0, 0);
    bus.entry_req = 1'b1;
    wait_open("lastcyc");
    bus.entry_req = 1'b0;
    do_pass(32);
    check("lastcyc_occ",     int'(bus.occupancy),     16);
    check("lastcyc_full",    int'(bus.full),          1);
    check("lastcyc_timeout", int'(bus.timeout_pulse), 0);
    cyc(8);

    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
